nvram_uploader: RTL
===================

NVRAM_UPLOADER -- requirements
Module: nvram_uploader

Interface
REQ-001 Parameter NV_INDEX, default 4: the ioctl_index value that selects this block.
REQ-002 Parameter NV_SIZE, default 1024: number of CMOS locations.
REQ-003 Parameter NV_AW, default 10: CMOS address width.
REQ-004 Parameter RD_LAT, default 1: CMOS read latency in cycles, range 1..3.
REQ-005 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 ioctl_upload  in  1  HPS upload in progress (level).
REQ-008 ioctl_index  in  16  HPS transfer index.
REQ-009 ioctl_rd  in  1  one-cycle HPS read strobe for the byte at ioctl_addr.
REQ-010 ioctl_addr  in  25  byte address requested by the HPS.
REQ-011 ioctl_din  out  8  byte returned to the HPS.
REQ-012 ioctl_upload_req  out  1  asks the HPS to start an upload.
REQ-013 save_trig  in  1  OSD save request (level; acts on rising edge).
REQ-014 cmos_we  in  1  CPU write strobe to the CMOS RAM.
REQ-015 pause_req  out  1  asks the game CPU to halt while the CMOS port is borrowed.
REQ-016 pause_ack  in  1  CPU halted.
REQ-017 nv_addr  out  NV_AW  CMOS read address.
REQ-018 nv_rd  out  1  CMOS read enable.
REQ-019 nv_q  in  4  CMOS read data, valid RD_LAT cycles after nv_rd.
REQ-020 dirty  out  1  CMOS modified since the last completed upload.
REQ-021 busy  out  1  FSM not in IDLE.

Function
REQ-022 Selection: sel = ioctl_upload && (ioctl_index == NV_INDEX); when sel=0, ioctl_rd is ignored.
REQ-023 FSM states: IDLE, ARB, READY, FETCH, HOLD.
REQ-024 IDLE->ARB when sel rises; pause_req=1 from the next cycle.
REQ-025 ARB->READY on pause_ack=1; if sel drops while in ARB, go to IDLE and drop pause_req.
REQ-026 READY->FETCH on ioctl_rd with ioctl_addr < NV_SIZE: nv_addr=ioctl_addr[NV_AW-1:0], nv_rd=1 for exactly one cycle.
REQ-027 FETCH counts RD_LAT cycles, then latches ioctl_din={4'h0,nv_q} and goes to HOLD; ioctl_din is updated exactly RD_LAT+1 cycles after ioctl_rd.
REQ-028 READY, ioctl_rd with ioctl_addr >= NV_SIZE: ioctl_din=8'hFF on the next cycle, no nv_rd, stay in READY.
REQ-029 HOLD->READY the next cycle; ioctl_din holds its value until the next read completes.
REQ-030 ioctl_rd in FETCH or HOLD is ignored; no queueing.
REQ-031 READY/FETCH/HOLD->IDLE when sel falls; an in-flight FETCH is abandoned; pause_req=0 the next cycle.
REQ-032 A transfer is complete when sel falls after a read of address NV_SIZE-1 was returned; completion clears dirty.
REQ-033 cmos_we=1 sets dirty on the next cycle; if set and clear coincide, set wins.
REQ-034 A save_trig rising edge while in IDLE with sel=0 sets ioctl_upload_req; it stays 1 until sel rises, then clears. Edges in any other state are ignored.
REQ-035 busy=1 in every state except IDLE; pause_req=1 in ARB, READY, FETCH and HOLD.

Reset
REQ-036 reset_n=0 at a clock edge puts the FSM in IDLE and zeroes ioctl_din, ioctl_upload_req, pause_req, nv_rd, nv_addr, busy and dirty, with the save_trig edge detector primed to the current level.
REQ-037 Reset mid-transfer releases pause_req on the first reset cycle regardless of pause_ack.

Verification
REQ-038 sel rises, pause_ack arrives 5 cycles later -> pause_req high throughout; READY entered the cycle after pause_ack.
REQ-039 RD_LAT=1, CMOS[0x123]=4'hA, ioctl_rd at addr 0x123 -> nv_rd pulse with nv_addr=0x123; ioctl_din=8'h0A 2 cycles after ioctl_rd.
REQ-040 ioctl_rd at addr 0x400 (NV_SIZE=1024) -> ioctl_din=8'hFF next cycle, nv_rd never asserted.
REQ-041 cmos_we pulse -> dirty=1; full upload of 0..1023, then sel falls -> dirty=0; an upload stopped at 512 leaves dirty=1.
REQ-042 save_trig rises in IDLE -> ioctl_upload_req=1 held until sel rises; a second edge while busy produces no new request.
REQ-043 reset_n=0 during FETCH -> all outputs 0 next cycle; after release, sel still high -> re-enters ARB.

Source files
------------

// File: rtl/nvram_uploader.sv
// Streams the 4-bit CMOS/NVRAM contents to the HPS on upload requests for NV_INDEX,
// pausing the game CPU while the CMOS read port is borrowed, and tracks unsaved changes.
module nvram_uploader #(
    parameter int unsigned NV_INDEX = 4,
    parameter int unsigned NV_SIZE  = 1024,
    parameter int unsigned NV_AW    = 10,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ioctl_upload,
    input  logic [15:0]      ioctl_index,
    input  logic             ioctl_rd,
    input  logic [24:0]      ioctl_addr,
    output logic [7:0]       ioctl_din,
    output logic             ioctl_upload_req,
    input  logic             save_trig,
    input  logic             cmos_we,
    output logic             pause_req,
    input  logic             pause_ack,
    output logic [NV_AW-1:0] nv_addr,
    output logic             nv_rd,
    input  logic [3:0]       nv_q,
    output logic             dirty,
    output logic             busy
);

    localparam logic [15:0] INDEX_L  = 16'(NV_INDEX);
    localparam logic [24:0] SIZE_L   = 25'(NV_SIZE);
    localparam logic [24:0] LAST_L   = 25'(NV_SIZE - 1);
    localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_READY,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t     state_q, state_d;
    logic       sel, sel_q, sel_rise;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] din_q, din_d;
    logic       last_q, last_d;
    logic       done_q, done_d;
    logic       req_q, req_d;
    logic       dirty_q, dirty_d;
    logic       trig_q, trig_rise;
    logic       in_range, rd_hit, rd_miss, complete;

    assign sel       = ioctl_upload && (ioctl_index == INDEX_L);
    assign sel_rise  = sel && !sel_q;
    assign trig_rise = save_trig && !trig_q;
    assign in_range  = (ioctl_addr < SIZE_L);
    assign rd_hit    = (state_q == S_READY) && sel && ioctl_rd && in_range;
    assign rd_miss   = (state_q == S_READY) && sel && ioctl_rd && !in_range;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        last_d   = last_q;
        done_d   = done_q;
        complete = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (sel_rise) begin
                    state_d = S_ARB;
                    done_d  = 1'b0;
                end
            end
            S_ARB: begin
                if (!sel) begin
                    state_d = S_IDLE;
                end else if (pause_ack) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (!sel) begin
                    state_d  = S_IDLE;
                    complete = done_q;
                end else if (rd_hit) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    last_d  = (ioctl_addr == LAST_L);
                end else if (rd_miss) begin
                    din_d = 8'hFF;
                end
            end
            S_FETCH: begin
                // Losing selection abandons the fetch: no data latched, no completion credit
                if (!sel) begin
                    state_d  = S_IDLE;
                    complete = done_q;
                end else if (cnt_q == LAT_LAST) begin
                    state_d = S_HOLD;
                    din_d   = {4'h0, nv_q};
                    done_d  = done_q | last_q;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_HOLD: begin
                if (!sel) begin
                    state_d  = S_IDLE;
                    complete = done_q;
                end else begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_d = req_q;
        if (sel_rise) begin
            req_d = 1'b0;
        end else if ((state_q == S_IDLE) && !sel && trig_rise) begin
            req_d = 1'b1;
        end
    end

    assign dirty_d = cmos_we | (dirty_q & ~complete);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            din_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            dirty_q <= 1'b0;
            trig_q  <= save_trig;
        end else begin
            state_q <= state_d;
            sel_q   <= sel;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            last_q  <= last_d;
            done_q  <= done_d;
            req_q   <= req_d;
            dirty_q <= dirty_d;
            trig_q  <= save_trig;
        end
    end

    // Read strobe is issued in the ioctl_rd cycle so data lands RD_LAT+1 cycles after the request
    assign nv_rd            = rd_hit;
    assign nv_addr          = rd_hit ? ioctl_addr[NV_AW-1:0] : '0;
    assign ioctl_din        = din_q;
    assign ioctl_upload_req = req_q;
    assign dirty            = dirty_q;
    assign busy             = (state_q != S_IDLE);
    assign pause_req        = (state_q != S_IDLE);

endmodule
